alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Upstream stage of the ALU. Buffers operand/op-code commands from the stimulus side in a FIFO.
- Issues commands to the ALU one at a time and waits for the ALU's ready pulse.
- Captures out/carry into a result register with a valid/ready handshake toward the result consumer.
- Guards each ALU operation with a timeout counter.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TIMEOUT, 16, cycles to wait for alu_ready after issue before flagging an error.

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept (not full)
- cmd_a  input  32  operand A
- cmd_b  input  32  operand B
- cmd_op  input  3  ALU op code
- alu_a  output  32  operand A to ALU
- alu_b  output  32  operand B to ALU
- alu_op_code  output  3  op code to ALU
- alu_start  output  1  one-cycle issue strobe
- alu_ready  input  1  ALU done pulse; alu_out/alu_carry valid this cycle
- alu_out  input  32  ALU result
- alu_carry  input  1  ALU carry
- rslt_valid  output  1  result register holds an unconsumed result
- rslt_ready  input  1  consumer accepts result
- rslt_out  output  32  captured result
- rslt_carry  output  1  captured carry
- timeout_err  output  1  sticky; set on ALU timeout
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, fifo_count=0, cmd_ready=1, FSM=IDLE, alu_start=0, alu_a/alu_b/alu_op_code=0, rslt_valid=0, rslt_out=0, rslt_carry=0, timeout_err=0, timeout counter=0. Reset mid-operation aborts any in-flight command; a late alu_ready pulse arriving in IDLE is ignored.
- FIFO:
  - Push when cmd_valid && cmd_ready. cmd_ready = (fifo_count != DEPTH).
  - Pop only on FSM IDLE->ISSUE.
  - Simultaneous push and pop when full: push is refused (cmd_ready=0 that cycle). Simultaneous push and pop when not full: count unchanged.
  - Read/write pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT, HOLD:
  - IDLE: if FIFO non-empty and rslt_valid=0, pop the head into alu_a/alu_b/alu_op_code, go to ISSUE.
  - ISSUE: alu_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
  - WAIT:
    - Operands held stable.
    - On alu_ready: capture alu_out/alu_carry into rslt_out/rslt_carry, set rslt_valid=1, go to HOLD.
    - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without alu_ready: set timeout_err, discard the command, go to IDLE.
  - HOLD: wait until rslt_valid && rslt_ready, which clears rslt_valid; go to IDLE.
- Latency: command accepted at edge N into an empty FIFO with an idle FSM gives pop at N+1, alu_start high in cycle N+2. alu_ready in cycle N+2 is ignored, because only WAIT samples it. Result is visible the cycle after alu_ready.
- At most one command in flight. A new issue never starts while rslt_valid=1.
- rslt_out/rslt_carry are stable while rslt_valid=1 and rslt_ready=0.
- timeout_err is cleared only by reset. Operation continues after a timeout.
- alu_op_code is passed through unmodified. All 8 codes are legal at this stage.

Decomposition:
- Shared package alu_pkg holds:
  - typedef issuer_state_e (IDLE, ISSUE, WAIT, HOLD)
  - typedef alu_cmd_t struct {a[31:0], b[31:0], op_code[2:0]}
  - localparams for operand width (32) and op-code width (3)
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t, parameter DEPTH, with push/pop/count/full/empty.

Test Plan:
- Single command: reset, push a=5, b=7, op=0. Expect alu_start exactly 2 cycles after accept with alu_a=5, alu_b=7. ALU model returns out=12, carry=0 three cycles later. Expect rslt_valid=1, rslt_out=12 on the next cycle; after rslt_ready, rslt_valid=0.
- Backpressure and full: hold rslt_ready=0 and push DEPTH+2 commands. Expect cmd_ready=0 once fifo_count=4 (DEPTH=4). No further alu_start while rslt_valid=1. Release rslt_ready and expect all commands issued in push order.
- Carry capture: push a=32'hFFFF_FFFF, b=1. ALU model returns out=0, carry=1. Expect rslt_out=0, rslt_carry=1, held stable across 5 cycles of rslt_ready=0.
- Timeout: ALU model never asserts alu_ready. Expect timeout_err=1 after TIMEOUT wait cycles, FSM back in IDLE. Next queued command issues and completes normally; timeout_err stays 1.
- Reset mid-operation: assert rst in WAIT with 2 entries queued. Expect fifo_count=0, rslt_valid=0, alu_start=0. A stray alu_ready one cycle later produces no rslt_valid.
- Simultaneous push/pop: with fifo_count=2, push in the same cycle as a pop. Expect fifo_count to remain 2 and pointer wrap after 10 back-to-back commands with correct ordering.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared state, command type and widths for the ALU command issuer
package alu_pkg;
  localparam int DW = 32;
  localparam int OPW = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} issuer_state_e;
  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op_code;
  } alu_cmd_t;
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous command FIFO; push refused when full, pop ignored when empty
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  alu_cmd_t               i_din,
  output alu_cmd_t               o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  alu_cmd_t r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_dout = r_mem[r_rp];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
    end else begin
      r_wp <= w_push ? r_wp + AW'(1) : r_wp;
      r_rp <= w_pop ? r_rp + AW'(1) : r_rp;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers ALU commands, issues them one at a time, captures results
// behind a valid/ready handshake and flags ALU timeouts with a sticky error.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [DW-1:0]          cmd_a,
  input  logic [DW-1:0]          cmd_b,
  input  logic [OPW-1:0]         cmd_op,
  output logic [DW-1:0]          alu_a,
  output logic [DW-1:0]          alu_b,
  output logic [OPW-1:0]         alu_op_code,
  output logic                   alu_start,
  input  logic                   alu_ready,
  input  logic [DW-1:0]          alu_out,
  input  logic                   alu_carry,
  output logic                   rslt_valid,
  input  logic                   rslt_ready,
  output logic [DW-1:0]          rslt_out,
  output logic                   rslt_carry,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CW = $clog2(TIMEOUT + 1);
  issuer_state_e r_state, w_next;
  alu_cmd_t r_cmd, w_head, w_din;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_rslt_out;
  logic r_rslt_valid, r_rslt_carry, r_timeout;
  logic w_full, w_empty, w_pop, w_capture, w_timeout, w_consume;
  assign w_din = {cmd_a, cmd_b, cmd_op};
  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .i_push(cmd_valid), .i_pop(w_pop), .i_din(w_din),
    .o_dout(w_head), .o_count(fifo_count), .o_full(w_full), .o_empty(w_empty)
  );
  assign cmd_ready = !w_full;
  assign alu_a = r_cmd.a;
  assign alu_b = r_cmd.b;
  assign alu_op_code = r_cmd.op_code;
  assign alu_start = r_state == ISSUE;
  assign rslt_valid = r_rslt_valid;
  assign rslt_out = r_rslt_out;
  assign rslt_carry = r_rslt_carry;
  assign timeout_err = r_timeout;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // alu_ready is only honoured in WAIT, so strays in other states are dropped
  always_comb begin
    w_next = r_state;
    w_pop = 1'b0;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    w_consume = 1'b0;
    case (r_state)
      IDLE: if (!w_empty && !r_rslt_valid) begin
        w_pop = 1'b1;
        w_next = ISSUE;
      end
      ISSUE: w_next = WAIT;
      WAIT: if (alu_ready) begin
        w_capture = 1'b1;
        w_next = HOLD;
      end else if (r_cnt == CW'(TIMEOUT - 1)) begin
        w_timeout = 1'b1;
        w_next = IDLE;
      end
      HOLD: if (r_rslt_valid && rslt_ready) begin
        w_consume = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd <= '0;
      r_cnt <= '0;
      r_rslt_valid <= 1'b0;
      r_rslt_out <= '0;
      r_rslt_carry <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cmd <= w_pop ? w_head : r_cmd;
      r_cnt <= r_state == ISSUE ? '0 : (r_state == WAIT && !alu_ready) ? r_cnt + CW'(1) : r_cnt;
      r_rslt_valid <= w_capture ? 1'b1 : w_consume ? 1'b0 : r_rslt_valid;
      r_rslt_out <= w_capture ? alu_out : r_rslt_out;
      r_rslt_carry <= w_capture ? alu_carry : r_rslt_carry;
      r_timeout <= r_timeout | w_timeout;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench with a latency-programmable ALU stub
module tb_alu_cmd_issuer;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } cmd_s;
  logic clk = 0, rst = 1, cmd_valid = 0, alu_ready = 0, alu_carry = 0, rslt_ready = 0;
  logic [31:0] cmd_a = 0, cmd_b = 0, alu_out = 0;
  logic [2:0] cmd_op = 0;
  logic cmd_ready, alu_start, rslt_valid, rslt_carry, timeout_err;
  logic [31:0] alu_a, alu_b, rslt_out;
  logic [2:0] alu_op_code, fifo_count;
  int total = 0, bad = 0;
  cmd_s exp_cmd[$];
  logic [32:0] exp_res[$];
  int alu_lat = 3, alu_wait = -1;
  bit alu_mute = 0, alu_kick = 0;
  logic [32:0] alu_pend, got_res, want_res;
  cmd_s got_cmd, want_cmd;

  alu_cmd_issuer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code), .alu_start(alu_start),
    .alu_ready(alu_ready), .alu_out(alu_out), .alu_carry(alu_carry),
    .rslt_valid(rslt_valid), .rslt_ready(rslt_ready), .rslt_out(rslt_out),
    .rslt_carry(rslt_carry), .timeout_err(timeout_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    return op == 3'd0 ? {1'b0, a} + {1'b0, b} : {op[0], a ^ b};
  endfunction

  // ALU stub, issue scoreboard and result scoreboard, sampled mid low phase
  always begin
    @(negedge clk);
    #2;
    alu_ready = 0;
    if (rst) alu_wait = -1;
    else if (alu_kick) begin
      alu_ready = 1;
      alu_out = 32'h1234_5678;
      alu_carry = 1;
    end
    if (alu_wait > 0) alu_wait--;
    if (alu_wait == 0) begin
      {alu_carry, alu_out} = alu_pend;
      alu_ready = 1;
      alu_wait = -1;
    end
    if (alu_start === 1'b1) begin
      total++;
      if (rslt_valid !== 1'b0) begin
        bad++;
        $display("FAIL issue_while_valid: rslt_valid=%b want 0", rslt_valid);
      end
      total++;
      got_cmd = {alu_a, alu_b, alu_op_code};
      if (exp_cmd.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got %h want none", got_cmd);
      end else begin
        want_cmd = exp_cmd.pop_front();
        if (got_cmd !== want_cmd) begin
          bad++;
          $display("FAIL issue_cmd: got %h want %h", got_cmd, want_cmd);
        end
      end
      if (!alu_mute) begin
        alu_pend = model(alu_a, alu_b, alu_op_code);
        alu_wait = alu_lat;
      end
    end
    if (rslt_valid === 1'b1 && rslt_ready === 1'b1) begin
      total++;
      got_res = {rslt_carry, rslt_out};
      if (exp_res.size() == 0) begin
        bad++;
        $display("FAIL result_unexpected: got %h want none", got_res);
      end else begin
        want_res = exp_res.pop_front();
        if (got_res !== want_res) begin
          bad++;
          $display("FAIL result: got %h want %h", got_res, want_res);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input bit res);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_wait: cmd_ready=%b want 1", cmd_ready);
      return;
    end
    cmd_valid = 1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    exp_cmd.push_back({a, b, op});
    if (res) exp_res.push_back(model(a, b, op));
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 400 && (exp_cmd.size() != 0 || exp_res.size() != 0); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++;
    if (exp_cmd.size() != 0 || exp_res.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: cmds=%0d results=%0d want 0 0", name, exp_cmd.size(), exp_res.size());
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({fifo_count, cmd_ready, alu_start, rslt_valid, rslt_carry, timeout_err} !== {3'd0, 5'b10000}) begin
      bad++;
      $display("FAIL reset_ctl: cnt=%0d rdy=%b st=%b v=%b c=%b to=%b", fifo_count, cmd_ready, alu_start, rslt_valid, rslt_carry, timeout_err);
    end
    total++;
    if ({alu_a, alu_b, alu_op_code, rslt_out} !== '0) begin
      bad++;
      $display("FAIL reset_data: a=%h b=%h op=%h out=%h want 0", alu_a, alu_b, alu_op_code, rslt_out);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    alu_lat = 3;
    rslt_ready = 0;
    push(32'd5, 32'd7, 3'd0, 1);
    total++;
    if (fifo_count !== 3'd1 || alu_start !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: cnt=%0d start=%b want 1 0", fifo_count, alu_start);
    end
    @(negedge clk);
    total++;
    if (alu_start !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op_code !== 3'd0) begin
      bad++;
      $display("FAIL single_issue: start=%b a=%0d b=%0d op=%0d want 1 5 7 0", alu_start, alu_a, alu_b, alu_op_code);
    end
    repeat (3) @(negedge clk);
    total++;
    if (rslt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early: rslt_valid=%b want 0", rslt_valid);
    end
    @(negedge clk);
    total++;
    if (rslt_valid !== 1'b1 || rslt_out !== 32'd12 || rslt_carry !== 1'b0) begin
      bad++;
      $display("FAIL single_result: v=%b out=%0d c=%b want 1 12 0", rslt_valid, rslt_out, rslt_carry);
    end
    rslt_ready = 1;
    @(negedge clk);
    total++;
    if (rslt_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_consume: rslt_valid=%b want 0", rslt_valid);
    end
    rslt_ready = 0;
    drain("single");
  endtask

  task automatic test_backpressure();
    int n = 0;
    alu_lat = 2;
    rslt_ready = 0;
    for (int i = 0; i < 5; i++) push(32'h100 + i, 32'h10 * i, 3'(i + 1), 1);
    repeat (6) @(negedge clk);
    total++;
    if (fifo_count !== 3'd4 || cmd_ready !== 1'b0 || rslt_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_full: cnt=%0d rdy=%b v=%b want 4 0 1", fifo_count, cmd_ready, rslt_valid);
    end
    cmd_valid = 1;
    cmd_a = 32'hABCD;
    cmd_b = 32'h1;
    cmd_op = 3'd0;
    repeat (3) @(negedge clk);
    total++;
    if (fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL bp_refuse: cnt=%0d want 4", fifo_count);
    end
    rslt_ready = 1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp_cmd.push_back({32'hABCD, 32'h1, 3'd0});
    exp_res.push_back(model(32'hABCD, 32'h1, 3'd0));
    @(negedge clk);
    cmd_valid = 0;
    drain("bp");
  endtask

  task automatic test_carry();
    int n = 0;
    alu_lat = 1;
    rslt_ready = 0;
    push(32'hFFFF_FFFF, 32'd1, 3'd0, 1);
    while (rslt_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rslt_valid !== 1'b1 || rslt_out !== 32'd0 || rslt_carry !== 1'b1) begin
        bad++;
        $display("FAIL carry_hold[%0d]: v=%b out=%h c=%b want 1 0 1", i, rslt_valid, rslt_out, rslt_carry);
      end
      @(negedge clk);
    end
    rslt_ready = 1;
    drain("carry");
  endtask

  task automatic test_timeout();
    alu_lat = 2;
    rslt_ready = 1;
    alu_mute = 1;
    push(32'hDEAD, 32'hBEEF, 3'd5, 0);
    @(negedge clk);
    total++;
    if (alu_start !== 1'b1) begin
      bad++;
      $display("FAIL to_issue: start=%b want 1", alu_start);
    end
    push(32'd40, 32'd2, 3'd0, 1);
    repeat (15) @(negedge clk);
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_early: timeout_err=%b want 0", timeout_err);
    end
    @(negedge clk);
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_flag: timeout_err=%b want 1", timeout_err);
    end
    alu_mute = 0;
    @(negedge clk);
    total++;
    if (alu_start !== 1'b1) begin
      bad++;
      $display("FAIL to_next_issue: start=%b want 1", alu_start);
    end
    drain("to");
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky: timeout_err=%b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    alu_lat = 10;
    rslt_ready = 1;
    for (int i = 0; i < 3; i++) push(32'h77 + i, 32'h3, 3'(i), 1);
    total++;
    if (fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL rm_queued: cnt=%0d want 2", fifo_count);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    exp_cmd.delete();
    exp_res.delete();
    total++;
    if (fifo_count !== 3'd0 || rslt_valid !== 1'b0 || alu_start !== 1'b0 || timeout_err !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rm_state: cnt=%0d v=%b st=%b to=%b rdy=%b want 0 0 0 0 1", fifo_count, rslt_valid, alu_start, timeout_err, cmd_ready);
    end
    alu_kick = 1;
    @(negedge clk);
    alu_kick = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (rslt_valid !== 1'b0 || alu_start !== 1'b0) begin
        bad++;
        $display("FAIL rm_stray[%0d]: v=%b st=%b want 0 0", i, rslt_valid, alu_start);
      end
    end
  endtask

  task automatic test_back_to_back();
    alu_lat = 1;
    rslt_ready = 0;
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 3'(i), 1);
    repeat (6) @(negedge clk);
    total++;
    if (rslt_valid !== 1'b1 || fifo_count !== 3'd2) begin
      bad++;
      $display("FAIL b2b_setup: v=%b cnt=%0d want 1 2", rslt_valid, fifo_count);
    end
    rslt_ready = 1;
    @(negedge clk);
    push($urandom, $urandom, 3'd3, 1);
    total++;
    if (fifo_count !== 3'd2 || alu_start !== 1'b1) begin
      bad++;
      $display("FAIL b2b_pushpop: cnt=%0d start=%b want 2 1", fifo_count, alu_start);
    end
    for (int i = 4; i < 10; i++) push($urandom, $urandom, 3'(i), 1);
    drain("b2b");
    total++;
    if (fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL b2b_empty: cnt=%0d want 0", fifo_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_carry();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
